// File: rtl/sobel_pkg.sv
// ============================================================================
// Package   : sobel_pkg
// Purpose   : Shared widths and types for the Sobel magnitude/pack stage.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package sobel_pkg;

  localparam int GRAD_W      = 11;
  localparam int PIX_W       = 8;
  localparam int LANES       = 4;
  localparam int LINE_PIXELS = 64;

  localparam int WORD_W    = LANES * PIX_W;
  localparam int LANE_W    = $clog2(LANES);
  localparam int PIX_CNT_W = $clog2(LINE_PIXELS);

  typedef logic [PIX_W-1:0]         pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

endpackage

`default_nettype wire

// File: rtl/sobel_abs_sat.sv
// ============================================================================
// Module    : sobel_abs_sat
// Purpose   : Combinational |gx|+|gy| saturated to one pixel. When
//             SOBEL_THRESHOLD_EN is defined the result is binarised against
//             thresh_i (>= threshold -> all ones, else zero).
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_abs_sat
  import sobel_pkg::*;
(
  input  grad_t  gx_i,
  input  grad_t  gy_i,
`ifdef SOBEL_THRESHOLD_EN
  input  pixel_t thresh_i,
`endif
  output pixel_t pix_o
);

  // One extra bit so that |-1024| = 1024 is representable, one more for the sum.
  localparam int                SUM_W   = GRAD_W + 2;
  localparam logic [SUM_W-1:0]  PIX_MAX = SUM_W'((1 << PIX_W) - 1);

  logic signed [GRAD_W:0] w_gx_ext, w_gy_ext;
  logic [GRAD_W:0]        w_gx_abs, w_gy_abs;
  logic [SUM_W-1:0]       w_sum;
  pixel_t                 w_sat;

  // Absolute values, unsigned sum and saturation to the pixel range.
  always_comb begin
    w_gx_ext = {gx_i[GRAD_W-1], gx_i};
    w_gy_ext = {gy_i[GRAD_W-1], gy_i};
    w_gx_abs = w_gx_ext[GRAD_W] ? $unsigned(-w_gx_ext) : $unsigned(w_gx_ext);
    w_gy_abs = w_gy_ext[GRAD_W] ? $unsigned(-w_gy_ext) : $unsigned(w_gy_ext);
    w_sum    = {1'b0, w_gx_abs} + {1'b0, w_gy_abs};
    w_sat    = (w_sum > PIX_MAX) ? '1 : w_sum[PIX_W-1:0];
  end

`ifdef SOBEL_THRESHOLD_EN
  // Binarise the saturated magnitude.
  assign pix_o = (w_sat >= thresh_i) ? '1 : '0;
`else
  assign pix_o = w_sat;
`endif

endmodule

`default_nettype wire

// File: rtl/sobel_mag_pack.sv
// ============================================================================
// Module    : sobel_mag_pack
// Purpose   : Converts (Gx,Gy) pairs to saturated magnitudes and packs LANES
//             pixels per output word (pixel 0 in the low byte) behind a
//             valid/ready handshake. Flags lines whose length differs from
//             LINE_PIXELS. Optional macro SOBEL_THRESHOLD_EN binarises each
//             pixel against cfg_thresh.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_mag_pack
  import sobel_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  grad_t             in_gx,
  input  grad_t             in_gy,
  input  logic              in_last,
  input  pixel_t            cfg_thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              line_err
);

  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [PIX_CNT_W-1:0] LAST_PIX  = PIX_CNT_W'(LINE_PIXELS - 1);

  logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [WORD_W-1:0]    pack_q, pack_d;
  logic                 out_valid_q, out_valid_d;
  logic [WORD_W-1:0]    out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 line_err_q, line_err_d;

  pixel_t               w_pix;
  logic [WORD_W-1:0]    w_word;
  logic                 w_accept;
  logic                 w_complete;

  sobel_abs_sat u_abs_sat (
    .gx_i     (in_gx),
    .gy_i     (in_gy),
`ifdef SOBEL_THRESHOLD_EN
    .thresh_i (cfg_thresh),
`endif
    .pix_o    (w_pix)
  );

`ifndef SOBEL_THRESHOLD_EN
  // Threshold input has no function without binarisation.
  logic w_unused_cfg;
  assign w_unused_cfg = ^cfg_thresh;
`endif

  // Pack register with the incoming pixel merged into the current lane.
  // Lanes above lane_cnt are still zero, so an early in_last pads with 0.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_word[gi*PIX_W +: PIX_W] = (lane_cnt_q == LANE_W'(gi)) ? w_pix
                                                                      : pack_q[gi*PIX_W +: PIX_W];
    end
  endgenerate

  assign in_ready   = !out_valid_q || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && (in_last || (lane_cnt_q == LAST_LANE));

  // Next-state: handshake, lane packing, and line-length checking.
  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    pack_d      = pack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    line_err_d  = line_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_accept) begin
      if (w_complete) begin
        lane_cnt_d  = '0;
        pack_d      = '0;
        out_valid_d = 1'b1;
        out_data_d  = w_word;
        out_last_d  = in_last;
      end else begin
        lane_cnt_d  = lane_cnt_q + LANE_W'(1);
        pack_d      = w_word;
      end

      if (in_last) begin
        pix_cnt_d = '0;
        if (pix_cnt_q != LAST_PIX) begin
          line_err_d = 1'b1;
        end
      end else if (pix_cnt_q == LAST_PIX) begin
        pix_cnt_d  = '0;
        line_err_d = 1'b1;
      end else begin
        pix_cnt_d  = pix_cnt_q + PIX_CNT_W'(1);
      end
    end
  end

  // State registers; reset discards any partially packed word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      line_err_q  <= line_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign line_err  = line_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_mag_pack.sv
// ============================================================================
// Module    : tb_sobel_mag_pack
// Purpose   : Self-checking bench for sobel_mag_pack (vector table, directed
//             corner sequences and randomized traffic against a model).
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_mag_pack;
  import sobel_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  grad_t       in_gx = '0;
  grad_t       in_gy = '0;
  pixel_t      cfg_thresh = 8'h80;
  logic        in_ready, out_valid, out_last, line_err;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  sobel_mag_pack dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_gx      (in_gx),
    .in_gy      (in_gy),
    .in_last    (in_last),
    .cfg_thresh (cfg_thresh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .line_err   (line_err)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic rnd_on = 1'b0;

  typedef struct { logic [31:0] data; logic last; } word_t;
  word_t      exp_q[$];
  logic [7:0] lane_m[$];
  int         line_len_m = 0;
  logic       err_m = 1'b0;
  int         xfer_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: condition not met", name);
  endtask

  // Reference pixel: plain integer |gx|+|gy| clipped to 255.
  function automatic logic [7:0] ref_pix(input int gx, input int gy);
    int s;
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (s > 255) s = 255;
`ifdef SOBEL_THRESHOLD_EN
    return (s >= int'(cfg_thresh)) ? 8'hFF : 8'h00;
`else
    return 8'(s);
`endif
  endfunction

  // Reference packer and line-length tracker, updated on each accept.
  task automatic model_accept(input int gx, input int gy, input logic last);
    word_t w;
    lane_m.push_back(ref_pix(gx, gy));
    if (last || lane_m.size() == LANES) begin
      w.data = '0;
      foreach (lane_m[i]) w.data[i*8 +: 8] = lane_m[i];
      w.last = last;
      exp_q.push_back(w);
      lane_m.delete();
    end
    line_len_m++;
    if (last) begin
      if (line_len_m != LINE_PIXELS) err_m = 1'b1;
      line_len_m = 0;
    end else if (line_len_m == LINE_PIXELS) begin
      err_m = 1'b1;
      line_len_m = 0;
    end
  endtask

  // Output monitor: every transferred word must match the model queue.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got %h expected no word", out_data);
      end else begin
        chk("word_data", out_data, exp_q[0].data);
        chk("word_last", {31'b0, out_last}, {31'b0, exp_q[0].last});
        void'(exp_q.pop_front());
      end
    end
  end

  // Random backpressure while rnd_on is set.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int gx, input int gy, input logic last);
    int n;
    logic ok;
    n = 0;
    ok = 1'b1;
    in_gx = GRAD_W'(gx);
    in_gy = GRAD_W'(gy);
    in_last = last;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        fail("send_timeout");
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk);
    if (ok) model_accept(gx, gy, last);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("line_err", {31'b0, line_err}, {31'b0, err_m});
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    lane_m.delete();
    line_len_m = 0;
    err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_line_err", {31'b0, line_err}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0][10:0] gx;
    logic [3:0][10:0] gy;
    logic [31:0]      exp;
  } vec_t;

  vec_t        tbl[4];
  logic [31:0] exp_w;
  int          nx;

  initial begin
    // Element [0] is the first pixel sent, landing in bits [7:0].
    tbl[0].gx = {11'(0),    11'(-1024), 11'(300), 11'(10)};
    tbl[0].gy = {11'(0),    11'(-1024), 11'(0),   11'(-20)};
    tbl[0].exp = 32'h00FF_FF1E;
    tbl[1].gx = {11'(-128), 11'(1),     11'(-3),  11'(-1020)};
    tbl[1].gy = {11'(-127), 11'(1),     11'(4),   11'(1020)};
    tbl[1].exp = 32'hFF02_07FF;
    tbl[2].gx = {11'(127),  11'(-1),    11'(100), 11'(0)};
    tbl[2].gy = {11'(128),  11'(-1),    11'(-100), 11'(-1)};
    tbl[2].exp = 32'hFF02_C801;
    tbl[3].gx = {11'(-1023), 11'(254),  11'(255), 11'(256)};
    tbl[3].gy = {11'(0),    11'(0),     11'(0),   11'(0)};
    tbl[3].exp = 32'hFFFE_FFFF;

    do_reset();

    // Vector table: one full word per entry, out_ready held high.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) send($signed(tbl[v].gx[i]), $signed(tbl[v].gy[i]), 1'b0);
      exp_w = tbl[v].exp;
`ifdef SOBEL_THRESHOLD_EN
      exp_w = exp_q[exp_q.size()-1].data;
`endif
      chk("tbl_valid", {31'b0, out_valid}, 32'd1);
      chk("tbl_data", out_data, exp_w);
      chk("tbl_last", {31'b0, out_last}, 32'd0);
    end

    // Backpressure: first word holds, fifth pair blocked, then drains with no bubble.
    idle(2);
    out_ready = 1'b0;
    send(1, 2, 1'b0); send(3, 4, 1'b0); send(5, 6, 1'b0); send(7, 8, 1'b0);
    in_gx = GRAD_W'(9);
    in_gy = GRAD_W'(10);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_out_data", out_data, exp_q[0].data);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    nx = xfer_cyc.size();
    send(9, 10, 1'b0); send(11, 12, 1'b0); send(13, 14, 1'b0); send(15, 16, 1'b0);
    idle(2);
    chk("drain_count", 32'(xfer_cyc.size() - nx), 32'd2);
    if (xfer_cyc.size() >= nx + 2) chk("drain_gap", 32'(xfer_cyc[nx+1] - xfer_cyc[nx]), 32'd4);
    else fail("drain_gap");

    // Back-to-back single-pixel words: one transfer per cycle.
    nx = xfer_cyc.size();
    send(1, 0, 1'b1); send(2, 0, 1'b1); send(3, 0, 1'b1);
    idle(2);
    chk("b2b_count", 32'(xfer_cyc.size() - nx), 32'd3);
    if (xfer_cyc.size() >= nx + 3) begin
      chk("b2b_gap0", 32'(xfer_cyc[nx+1] - xfer_cyc[nx]), 32'd1);
      chk("b2b_gap1", 32'(xfer_cyc[nx+2] - xfer_cyc[nx+1]), 32'd1);
    end else fail("b2b_gap");

    // Randomized traffic with random backpressure and occasional in_last.
    rnd_on = 1'b1;
    for (int k = 0; k < 300; k++) begin
      cfg_thresh = 8'($urandom);
      send(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
           1'($urandom_range(0, 15) == 0));
    end
    rnd_on = 1'b0;
    idle(1);
    out_ready = 1'b1;
    cfg_thresh = 8'h80;
    idle(4);
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    // Full 64-pixel line closed correctly.
    do_reset();
    nx = xfer_cyc.size();
    for (int p = 0; p < LINE_PIXELS; p++)
      send(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300, 1'(p == LINE_PIXELS - 1));
    idle(2);
    chk("line64_words", 32'(xfer_cyc.size() - nx), 32'd16);
    chk("line64_err", {31'b0, line_err}, 32'd0);
    chk("line64_last", {31'b0, out_last}, 32'd1);

    // Short line: in_last on the 6th pixel pads the second word.
    for (int p = 0; p < 6; p++) send(p * 10 + 1, -p, 1'(p == 5));
    idle(2);
    chk("short_err", {31'b0, line_err}, 32'd1);
    chk("short_last", {31'b0, out_last}, 32'd1);
    chk("short_upper", {16'b0, out_data[31:16]}, 32'd0);

    // Reset mid-word: immediate clear, then a fresh word from lane 0.
    send(5, 5, 1'b0); send(6, 6, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_out_data", out_data, 32'd0);
    chk("async_out_last", {31'b0, out_last}, 32'd0);
    chk("async_line_err", {31'b0, line_err}, 32'd0);
    do_reset();
    send(127, 0, 1'b0); send(128, 0, 1'b0); send(0, -128, 1'b0); send(1, 126, 1'b0);
`ifdef SOBEL_THRESHOLD_EN
    chk("fresh_word", out_data, 32'h00FF_FF00);
`else
    chk("fresh_word", out_data, 32'h7F80_807F);
`endif
    chk("fresh_valid", {31'b0, out_valid}, 32'd1);

    idle(3);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
